// File: rtl/execute_pkg.sv
// Shared execute-stage types: datapath word, multicycle unit state and the
// HI/LO in-flight write slot carried through the M and W pipeline slots.
package execute_pkg;

    typedef logic [31:0] word_t;

    // Multicycle (mult/div) unit activity as seen by the execute stage.
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_MULT = 2'd1,
        MC_DIV  = 2'd2,
        MC_DONE = 2'd3
    } multicycle_t;

    // One in-flight HI/LO write.
    typedef struct packed {
        logic  valid;
        logic  we_hi;
        logic  we_lo;
        word_t hi;
        word_t lo;
    } hilo_slot_t;

    localparam hilo_slot_t HILO_SLOT_EMPTY = '{
        valid: 1'b0,
        we_hi: 1'b0,
        we_lo: 1'b0,
        hi:    32'h0000_0000,
        lo:    32'h0000_0000
    };

    // Build a slot from execute-stage signals; a write enabling neither half
    // carries no architectural effect and is marked invalid.
    function automatic hilo_slot_t make_slot(
        input logic  wr_valid,
        input logic  we_hi,
        input logic  we_lo,
        input word_t hi,
        input word_t lo
    );
        hilo_slot_t s;
        s.valid = wr_valid & (we_hi | we_lo);
        s.we_hi = we_hi;
        s.we_lo = we_lo;
        s.hi    = hi;
        s.lo    = lo;
        return s;
    endfunction

endpackage

// File: rtl/hilo_pipe_reg.sv
// Single HI/LO write slot register. Loads d when the pipe advances, holds
// when stalled, and a flush always kills the held write even under stall.
module hilo_pipe_reg
    import execute_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       stall,
    input  logic       flush,
    input  hilo_slot_t d,
    output hilo_slot_t q
);

    hilo_slot_t nxt;

    // Next slot contents: advance, or hold with the flush still applied.
    always_comb begin
        nxt = q;
        if (stall) begin
            nxt.valid = q.valid & ~flush;
        end else begin
            nxt = d;
        end
    end

    // Slot state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= HILO_SLOT_EMPTY;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO pair with its M/W in-flight write pipeline. Writes
// leaving execute commit at the end of W; MFHI/MFLO reads in execute see the
// youngest surviving write per half, falling back to the architectural copy.
module hilo_unit
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flushM,
    input  logic        flushW,
    input  logic        wr_validE,
    input  logic        we_hiE,
    input  logic        we_loE,
    input  logic [31:0] hiE,
    input  logic [31:0] loE,
    output logic [31:0] hi_rd,
    output logic [31:0] lo_rd,
    output logic        pending
);

    hilo_slot_t slot_e;
    hilo_slot_t slot_m;
    hilo_slot_t slot_w_in;
    hilo_slot_t slot_w;
    word_t      hi_arch;
    word_t      lo_arch;
    logic       commit;

    // Execute-stage write presented to the M slot.
    always_comb begin
        slot_e = make_slot(wr_validE, we_hiE, we_loE, hiE, loE);
    end

    // M contents moving to W; a flush at M turns it into a bubble.
    always_comb begin
        slot_w_in       = slot_m;
        slot_w_in.valid = slot_m.valid & ~flushM;
    end

    hilo_pipe_reg u_slot_m (
        .clk    (clk),
        .resetn (resetn),
        .stall  (stall),
        .flush  (flushM),
        .d      (slot_e),
        .q      (slot_m)
    );

    hilo_pipe_reg u_slot_w (
        .clk    (clk),
        .resetn (resetn),
        .stall  (stall),
        .flush  (flushW),
        .d      (slot_w_in),
        .q      (slot_w)
    );

    // W write retires only when the pipe advances and W is not being killed.
    always_comb begin
        commit = ~stall & slot_w.valid & ~flushW;
    end

    // Architectural HI/LO; each half commits independently.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_arch <= 32'h0000_0000;
            lo_arch <= 32'h0000_0000;
        end else begin
            if (commit && slot_w.we_hi) begin
                hi_arch <= slot_w.hi;
            end else begin
                hi_arch <= hi_arch;
            end
            if (commit && slot_w.we_lo) begin
                lo_arch <= slot_w.lo;
            end else begin
                lo_arch <= lo_arch;
            end
        end
    end

    // HI read forwarding: M (younger) over W over architectural copy.
    always_comb begin
        if (slot_m.valid && slot_m.we_hi && !flushM) begin
            hi_rd = slot_m.hi;
        end else if (slot_w.valid && slot_w.we_hi && !flushW) begin
            hi_rd = slot_w.hi;
        end else begin
            hi_rd = hi_arch;
        end
    end

    // LO read forwarding, same priority as HI.
    always_comb begin
        if (slot_m.valid && slot_m.we_lo && !flushM) begin
            lo_rd = slot_m.lo;
        end else if (slot_w.valid && slot_w.we_lo && !flushW) begin
            lo_rd = slot_w.lo;
        end else begin
            lo_rd = lo_arch;
        end
    end

    // Any write still in flight.
    always_comb begin
        pending = slot_m.valid | slot_w.valid;
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus randomized
// traffic checked against a queue-of-in-flight-writes reference model.
module tb_hilo_unit;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        flushM;
    logic        flushW;
    logic        wr_validE;
    logic        we_hiE;
    logic        we_loE;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic [31:0] hi_rd;
    logic [31:0] lo_rd;
    logic        pending;

    int checks;
    int failures;

    hilo_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .stall     (stall),
        .flushM    (flushM),
        .flushW    (flushW),
        .wr_validE (wr_validE),
        .we_hiE    (we_hiE),
        .we_loE    (we_loE),
        .hiE       (hiE),
        .loE       (loE),
        .hi_rd     (hi_rd),
        .lo_rd     (lo_rd),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural values plus the in-flight writes,
    // oldest first (index 0 retires next, index 1 is the youngest).
    typedef struct {
        logic        alive;
        logic        wh;
        logic        wl;
        logic [31:0] h;
        logic [31:0] l;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    function automatic ent_t dead_ent();
        ent_t e;
        e.alive = 1'b0;
        e.wh = 1'b0;
        e.wl = 1'b0;
        e.h = 32'h0;
        e.l = 32'h0;
        return e;
    endfunction

    function automatic logic [31:0] pred_hi();
        logic [31:0] r;
        r = m_hi;
        if (mq[0].alive && mq[0].wh && !flushW) r = mq[0].h;
        if (mq[1].alive && mq[1].wh && !flushM) r = mq[1].h;
        return r;
    endfunction

    function automatic logic [31:0] pred_lo();
        logic [31:0] r;
        r = m_lo;
        if (mq[0].alive && mq[0].wl && !flushW) r = mq[0].l;
        if (mq[1].alive && mq[1].wl && !flushM) r = mq[1].l;
        return r;
    endfunction

    function automatic logic pred_pending();
        return mq[0].alive | mq[1].alive;
    endfunction

    task automatic drive(input logic st, input logic fm, input logic fw,
                         input logic v, input logic wh, input logic wl,
                         input logic [31:0] h, input logic [31:0] l);
        stall = st; flushM = fm; flushW = fw;
        wr_validE = v; we_hiE = wh; we_loE = wl; hiE = h; loE = l;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Advance one clock; update the model from the inputs at the edge.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (!resetn) begin
            m_hi = 32'h0;
            m_lo = 32'h0;
            mq.delete();
            mq.push_back(dead_ent());
            mq.push_back(dead_ent());
        end else begin
            if (flushM) mq[1].alive = 1'b0;
            if (flushW) mq[0].alive = 1'b0;
            if (!stall) begin
                e = mq.pop_front();
                if (e.alive && e.wh) m_hi = e.h;
                if (e.alive && e.wl) m_lo = e.l;
                e.alive = wr_validE & (we_hiE | we_loE);
                e.wh = we_hiE; e.wl = we_loE; e.h = hiE; e.l = loE;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        tick();
        tick();
        resetn = 1'b1;
        #1;
        checks++;
        if (hi_rd !== 32'h0 || lo_rd !== 32'h0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL reset: hi=%h lo=%h pend=%b expected 0/0/0", hi_rd, lo_rd, pending);
        end
    endtask

    task automatic test_mthi();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234, 32'hFFFF_FFFF);
        tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (hi_rd !== 32'h1234 || lo_rd !== 32'h0 || pending !== (k <= 2)) begin
                failures++;
                $display("FAIL mthi_t%0d: hi=%h lo=%h pend=%b expected 1234/0/%b",
                         k, hi_rd, lo_rd, pending, (k <= 2));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_hi[5];
        logic [31:0] exp_lo[5];
        exp_hi = '{32'hAAAA0000, 32'hAAAA0000, 32'h9, 32'h9, 32'h9};
        exp_lo = '{32'h5555, 32'h7, 32'h7, 32'h7, 32'h7};
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0000, 32'h5555);
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h7);
            else if (k == 1) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h9, 32'h0);
            else idle();
            #1;
            checks++;
            if (hi_rd !== exp_hi[k] || lo_rd !== exp_lo[k]) begin
                failures++;
                $display("FAIL b2b_t%0d: hi=%h lo=%h expected %h/%h",
                         k + 1, hi_rd, lo_rd, exp_hi[k], exp_lo[k]);
            end
            tick();
        end
        #1;
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: pending=%b expected 0", pending);
        end
    endtask

    task automatic test_flush_m();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hDEAD);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (lo_rd !== 32'h7) begin
            failures++;
            $display("FAIL flushm_fwd: lo=%h expected 00000007", lo_rd);
        end
        tick();
        idle();
        #1;
        checks++;
        if (pending !== 1'b0 || lo_rd !== 32'h7) begin
            failures++;
            $display("FAIL flushm_t2: pend=%b lo=%h expected 0/00000007", pending, lo_rd);
        end
        tick(); tick();
        checks++;
        if (lo_rd !== 32'h7) begin
            failures++;
            $display("FAIL flushm_arch: lo=%h expected 00000007", lo_rd);
        end
    endtask

    task automatic test_flush_w();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hBEEF, 32'h0);
        tick();
        idle();
        #1;
        checks++;
        if (hi_rd !== 32'hBEEF) begin
            failures++;
            $display("FAIL flushw_t1: hi=%h expected 0000beef", hi_rd);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (hi_rd !== 32'h9) begin
            failures++;
            $display("FAIL flushw_t2: hi=%h expected 00000009", hi_rd);
        end
        tick();
        idle();
        tick();
        checks++;
        if (hi_rd !== 32'h9 || pending !== 1'b0) begin
            failures++;
            $display("FAIL flushw_arch: hi=%h pend=%b expected 00000009/0", hi_rd, pending);
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0);
        tick();
        // Four stalled cycles, then two advancing cycles still in flight.
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFACE, 32'hCAFE);
            else idle();
            #1;
            checks++;
            if (hi_rd !== 32'h11 || pending !== (k <= 6)) begin
                failures++;
                $display("FAIL stall_t%0d: hi=%h pend=%b expected 00000011/%b",
                         k, hi_rd, pending, (k <= 6));
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h66);
        tick();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (hi_rd !== 32'h0 || lo_rd !== 32'h0 || pending !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_t%0d: hi=%h lo=%h pend=%b expected 0/0/0",
                         k, hi_rd, lo_rd, pending);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 99) >= 2);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                  1'($urandom), 1'($urandom), $urandom, $urandom);
            #1;
            checks++;
            if (hi_rd !== pred_hi() || lo_rd !== pred_lo() || pending !== pred_pending()) begin
                failures++;
                $display("FAIL random_%0d: hi=%h lo=%h pend=%b expected %h/%h/%b",
                         n, hi_rd, lo_rd, pending, pred_hi(), pred_lo(), pred_pending());
            end
            tick();
        end
        resetn = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        mq.push_back(dead_ent());
        mq.push_back(dead_ent());
        resetn = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_mthi();
        test_back_to_back();
        test_flush_m();
        test_flush_w();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register pair plus its in-flight write pipeline, sitting directly downstream of the execute-stage multicycle (mult/div) unit. The block captures HI/LO writes leaving execute, carries them through the M and W slots, and commits them to the architectural registers at the end of W. It serves MFHI/MFLO reads in execute with full forwarding from M, W and the architectural copy. Flushes from exceptions kill uncommitted writes so HI/LO stay precise.

## Interface
- No parameters; all datapaths are 32-bit `word_t`.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- stall  in  1  pipeline freeze: M/W slots hold and commit is suppressed
- flushM  in  1  kill the write currently in the M slot (exception at M)
- flushW  in  1  kill the write currently in the W slot (exception at W)
- wr_validE  in  1  execute stage presents a HI/LO write this cycle (mult/div with ok, MTHI, MTLO)
- we_hiE  in  1  write HI
- we_loE  in  1  write LO
- hiE  in  32  HI value to write
- loE  in  32  LO value to write
- hi_rd  out  32  forwarded HI for an MFHI in execute
- lo_rd  out  32  forwarded LO for an MFLO in execute
- pending  out  1  any valid write in M or W (debug / hazard visibility)

## Operation
- The slot contents are {valid, we_hi, we_lo, hi, lo}; there are two slots, M and W.
- E→M capture: when stall=0, the M slot loads valid=wr_validE&(we_hiE|we_loE) together with the fields. A write with both enables low is treated as invalid.
- M→W: when stall=0, the W slot loads the M slot. If flushM=1 in that cycle, the W slot loads valid=0 instead.
- Commit: when stall=0, W.valid=1 and flushW=0, HI←W.hi if W.we_hi and LO←W.lo if W.we_lo. Each half commits independently.
- stall=1:
  - M and W hold their contents and no commit occurs.
  - flushM still clears M.valid and flushW still clears W.valid, because a flush overrides stall.
- Read forwarding applies per half, independently.
  - hi_rd = M.hi if (M.valid & M.we_hi & ~flushM).
  - Otherwise hi_rd = W.hi if (W.valid & W.we_hi & ~flushW).
  - Otherwise hi_rd = HI.
  - lo_rd follows the same rule with we_lo and LO.
- The E-stage write is never forwarded to the same-cycle E read, because only one instruction occupies E.
- pending = M.valid | W.valid.

## Timing
- Reset (resetn=0 at a posedge):
  - HI=0 and LO=0.
  - M.valid=0 and W.valid=0; the slot data fields are also zeroed.
  - Consequently hi_rd=lo_rd=0 and pending=0 in the cycle after reset.
- Reset wins over stall and the flushes. If reset arrives mid-pipeline, all in-flight writes are lost.
- Write latency: for a write presented in cycle t with no stall:
  - it is in M in t+1 and in W in t+2;
  - it is architecturally visible from t+3;
  - a read in t+1 or t+2 returns the value through forwarding.
- Simultaneous writes: when M and W both hold writes to the same half, M takes priority (younger). After the W commit, the arch value is overwritten again by M in the next cycle.
- A stall spanning k cycles delays commit by exactly k cycles. Forwarded outputs remain stable during the stall.
- hi_rd and lo_rd are purely combinational from the slot registers, HI/LO and the flushes. There is no added latency.

## Structure
- Place `hilo_slot_t` (packed struct: valid, we_hi, we_lo, hi, lo) in `execute_pkg` next to `multicycle_t`.
- Use one sub-module, `hilo_pipe_reg`: a slot register with resetn, stall, flush and in/out ports, instantiated once for M and once for W.
- The architectural HI/LO registers, commit logic and forwarding mux live in the top level.

## Test plan
- Reset → hi_rd=0, lo_rd=0, pending=0. Then MTHI 0x1234 with no stall → hi_rd=0x1234 in t+1, t+2, t+3 and onward; LO stays 0.
- Three back-to-back writes: MULT result hi=0xAAAA0000/lo=0x5555, then MTLO 0x7, then MTHI 0x9. Reads each cycle must show younger-first forwarding. Final state is HI=0x9, LO=0x7.
- Write 0xDEAD to LO, then assert flushM in t+1 → lo_rd reverts to the prior LO in t+1. LO is never 0xDEAD, and pending=0 in t+2.
- Write 0xBEEF to HI, then assert flushW in t+2 → no commit occurs and HI keeps its old value.
- Write HI=0x11, then hold stall high for 4 cycles from t+1 → M and W hold, hi_rd=0x11 throughout, and the commit lands 4 cycles late.
- Assert resetn=0 while M and W both hold valid writes → HI=LO=0 and pending=0 on the next cycle; no later commit occurs.
